axis_bram_writer: RTL and testbench
===================================

Name: axis_bram_writer

Overview:
- AXI-Stream sink that captures incoming beats into a single-port BRAM, one word per beat, starting at address 0.
- Write-side counterpart of the AXIS BRAM streamer: a capture is filled here, then replayed by the reader.
- Supports one-shot capture of `limit` words or continuous ring capture.
- Optional frame alignment: capture can start only after a tlast has been seen.

Parameters:
- DATA_WIDTH, 16, width of stream data and BRAM word in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, BRAM word-address width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- limit  in  ADDR_WIDTH  words per capture; 0 means 2^ADDR_WIDTH. Sampled on arm.
- continuous  in  1  1 = ring mode; 0 = one-shot. Sampled on arm.
- sync_tlast  in  1  1 = wait for a tlast beat before writing. Sampled on arm.
- arm  in  1  start pulse.
- stop  in  1  abort / leave ring mode.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  stream last.
- s_axis_tready  out  1  stream ready.
- bram_wrdata  out  DATA_WIDTH  write data.
- bram_addr  out  ADDR_WIDTH  word address.
- bram_we  out  DATA_WIDTH/8  byte write enables.
- bram_en  out  1  BRAM enable.
- bram_clk  out  1  BRAM clock.
- sts_addr  out  ADDR_WIDTH  address of last word written.
- wrapped  out  1  sticky: ring wrapped at least once in this capture.
- busy  out  1  state is SYNC or CAPTURE.
- done  out  1  state is DONE.

Behaviour:
- Reset (aresetn=0, asynchronous): state=IDLE.
  - s_axis_tready=0, bram_we=0, bram_en=0.
  - bram_addr=0, bram_wrdata=0, sts_addr=0, wrapped=0.
  - Internal addr=0, internal_limit=0.
  - s_axis_tready goes to 1 on the first aclk edge after reset release and stays 1. The block never back-pressures; beats are discarded outside CAPTURE.
- bram_clk = aclk (combinational). bram_en = bram_we != 0.
- Accepted beat = s_axis_tvalid && s_axis_tready.
- IDLE / DONE:
  - On arm: latch internal_limit = limit-1 (ADDR_WIDTH wrap, so limit=0 gives all-ones), latch continuous and sync_tlast.
  - Also on arm: addr=0, wrapped=0; go to SYNC if sync_tlast else CAPTURE.
  - Beats arriving in the arm cycle are discarded.
- SYNC: discard beats. An accepted beat with tlast=1 moves the block to CAPTURE, and the next beat is the first one written. stop -> IDLE.
- CAPTURE, on each accepted beat:
  - Write cycle: next cycle bram_we=all ones, bram_addr=addr, bram_wrdata=tdata, sts_addr=addr. Write latency is 1 cycle. bram_we=0 in all other cycles.
  - If addr==internal_limit and continuous=0: addr=0, go to DONE.
  - If addr==internal_limit and continuous=1: addr=0, wrapped=1, stay in CAPTURE.
  - Otherwise addr=addr+1.
  - tlast has no effect in CAPTURE.
- stop in CAPTURE:
  - A beat accepted in the same cycle is still written; then go to IDLE, not DONE, even if that beat was the final one.
  - stop and arm together: stop wins in SYNC/CAPTURE. arm wins in IDLE/DONE (stop is ignored there).
- arm in SYNC/CAPTURE is ignored.
- limit changes mid-capture have no effect.
- Reset mid-capture: the write in flight is dropped (bram_we forced 0 asynchronously); state returns to IDLE.

Test Plan:
- One-shot: limit=4, continuous=0, sync_tlast=0, arm, then beats 0xA0..0xA5 back-to-back.
  - Writes (addr,data) = (0,A0),(1,A1),(2,A2),(3,A3), each 1 cycle after acceptance.
  - done=1 after the 4th beat; A4/A5 not written; sts_addr=3, wrapped=0.
- Ring: limit=3, continuous=1, arm, then 7 beats D0..D6.
  - Addresses 0,1,2,0,1,2,0; wrapped=1 after the 3rd beat; busy stays 1.
  - stop on the 7th beat: D6 written at addr 0, then IDLE, done=0.
- Frame sync: sync_tlast=1, limit=2, arm.
  - Beats B0, B1(tlast), B2, B3: only B2->0 and B3->1 are written; done=1.
- Full depth: ADDR_WIDTH=4, limit=0, one-shot, 16 beats.
  - Addresses 0..15 written; done after the 16th beat, not before.
- Idle gaps and reset: limit=4, tvalid toggling 1,0,1,1,0,1.
  - Exactly 4 writes at 0..3 with no writes on gap cycles.
  - Repeat with aresetn pulled low after 2 beats: bram_we=0 immediately; state IDLE; a subsequent arm restarts from addr 0.

Source files
------------

// File: rtl/axis_bram_writer_if.sv
// AXI-Stream handshake bundle used by the BRAM capture block.
`default_nettype none

interface axis_bram_writer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_bram_writer.sv
// ============================================================================
// Module      : axis_bram_writer
// Description : AXI-Stream sink capturing beats into a single-port BRAM,
//               one-shot or ring mode, with optional tlast frame alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_bram_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  wire logic                    aclk,
  input  wire logic                    aresetn,
  input  wire logic [ADDR_WIDTH-1:0]   limit,
  input  wire logic                    continuous,
  input  wire logic                    sync_tlast,
  input  wire logic                    arm,
  input  wire logic                    stop,
  axis_bram_writer_if.slave            s_axis,
  output logic [DATA_WIDTH-1:0]        bram_wrdata,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH/8-1:0]      bram_we,
  output logic                         bram_en,
  output logic                         bram_clk,
  output logic [ADDR_WIDTH-1:0]        sts_addr,
  output logic                         wrapped,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_limit;
  logic                  r_continuous;
  logic                  r_tready;
  logic                  w_accept;

  assign s_axis.tready = r_tready;
  assign w_accept      = s_axis.tvalid && r_tready;
  assign bram_clk      = aclk;
  assign bram_en       = |bram_we;
  assign busy          = (r_state == S_SYNC) || (r_state == S_CAPTURE);
  assign done          = (r_state == S_DONE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_limit      <= '0;
      r_continuous <= 1'b0;
      r_tready     <= 1'b0;
      bram_we      <= '0;
      bram_addr    <= '0;
      bram_wrdata  <= '0;
      sts_addr     <= '0;
      wrapped      <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      bram_we  <= '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            // limit=0 wraps to all-ones, i.e. the full 2^ADDR_WIDTH depth
            r_limit      <= limit - ADDR_WIDTH'(1);
            r_continuous <= continuous;
            r_addr       <= '0;
            wrapped      <= 1'b0;
            r_state      <= sync_tlast ? S_SYNC : S_CAPTURE;
          end
        end
        S_SYNC: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_accept && s_axis.tlast) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_accept) begin
            bram_we     <= '1;
            bram_addr   <= r_addr;
            bram_wrdata <= s_axis.tdata;
            sts_addr    <= r_addr;
            if (r_addr == r_limit) begin
              r_addr <= '0;
              if (r_continuous) begin
                wrapped <= 1'b1;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
          // stop overrides any DONE transition from a final beat
          if (stop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_bram_writer.sv
// Directed self-checking bench for axis_bram_writer (ADDR_WIDTH=4, DATA_WIDTH=16).
`default_nettype none

module tb_axis_bram_writer;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] limit;
  logic          continuous;
  logic          sync_tlast;
  logic          arm;
  logic          stop;
  logic [DW-1:0] bram_wrdata;
  logic [AW-1:0] bram_addr;
  logic [DW/8-1:0] bram_we;
  logic          bram_en;
  logic          bram_clk;
  logic [AW-1:0] sts_addr;
  logic          wrapped;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  axis_bram_writer_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .limit       (limit),
    .continuous  (continuous),
    .sync_tlast  (sync_tlast),
    .arm         (arm),
    .stop        (stop),
    .s_axis      (s_axis.slave),
    .bram_wrdata (bram_wrdata),
    .bram_addr   (bram_addr),
    .bram_we     (bram_we),
    .bram_en     (bram_en),
    .bram_clk    (bram_clk),
    .sts_addr    (sts_addr),
    .wrapped     (wrapped),
    .busy        (busy),
    .done        (done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log every BRAM write away from the active edge.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && bram_en === 1'b1) begin
      check("we_mask", 32'(bram_we), 32'(2'b11));
      wr_addr_q.push_back(bram_addr);
      wr_data_q.push_back(bram_wrdata);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [DW-1:0] d, input logic l);
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    tick();
  endtask

  task automatic do_arm(input logic [AW-1:0] lim, input logic cont, input logic syn);
    limit      = lim;
    continuous = cont;
    sync_tlast = syn;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    s_axis.tvalid = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_addr_q[idx]), ea);
      check({tag, "_data"}, 32'(wr_data_q[idx]), ed);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    aresetn = 1'b0;
    limit = '0; continuous = 1'b0; sync_tlast = 1'b0; arm = 1'b0; stop = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    tick(); tick();
    check("rst_tready", 32'(s_axis.tready), 0);
    check("rst_we",     32'(bram_we), 0);
    check("rst_en",     32'(bram_en), 0);
    check("rst_addr",   32'(bram_addr), 0);
    check("rst_wrdata", 32'(bram_wrdata), 0);
    check("rst_sts",    32'(sts_addr), 0);
    check("rst_wrap",   32'(wrapped), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    aresetn = 1'b1;
    tick();
    check("tready_up",  32'(s_axis.tready), 1);

    // One-shot, limit=4; a beat during the arm cycle must be dropped.
    s_axis.tvalid = 1'b1; s_axis.tdata = 16'h00EE;
    do_arm(4'd4, 1'b0, 1'b0);
    check("os_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, 16'h00A0 + 16'(i), 1'b0);
      if (i == 0) begin
        check("os_lat_we",   32'(bram_we), 32'(2'b11));
        check("os_lat_addr", 32'(bram_addr), 0);
        check("os_lat_data", 32'(bram_wrdata), 32'h00A0);
      end
      if (i == 2) check("os_done_early", 32'(done), 0);
      if (i == 3) check("os_done", 32'(done), 1);
    end
    s_axis.tvalid = 1'b0;
    tick();
    check("os_count", 32'(wr_addr_q.size()), 4);
    for (int i = 0; i < 4; i++) check_write("os_wr", i, 32'(i), 32'h00A0 + 32'(i));
    check("os_sts",  32'(sts_addr), 3);
    check("os_wrap", 32'(wrapped), 0);

    // Ring, limit=3; arm mid-capture is ignored, stop on the 7th beat.
    do_arm(4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      arm  = (i == 3);
      stop = (i == 6);
      beat(1'b1, 16'h00D0 + 16'(i), 1'b0);
      if (i == 1) check("ring_wrap_early", 32'(wrapped), 0);
      if (i == 2) check("ring_wrap", 32'(wrapped), 1);
      if (i == 5) check("ring_busy", 32'(busy), 1);
    end
    arm = 1'b0; stop = 1'b0; s_axis.tvalid = 1'b0;
    tick();
    check("ring_idle_busy", 32'(busy), 0);
    check("ring_idle_done", 32'(done), 0);
    check("ring_count", 32'(wr_addr_q.size()), 7);
    for (int i = 0; i < 7; i++) check_write("ring_wr", i, 32'(i % 3), 32'h00D0 + 32'(i));

    // Frame sync, limit=2: only the beats after the tlast beat are written.
    do_arm(4'd2, 1'b0, 1'b1);
    check("sync_busy", 32'(busy), 1);
    beat(1'b1, 16'h00B0, 1'b0);
    beat(1'b1, 16'h00B1, 1'b1);
    beat(1'b1, 16'h00B2, 1'b0);
    beat(1'b1, 16'h00B3, 1'b0);
    s_axis.tvalid = 1'b0;
    tick();
    check("sync_done",  32'(done), 1);
    check("sync_count", 32'(wr_addr_q.size()), 2);
    check_write("sync_wr0", 0, 0, 32'h00B2);
    check_write("sync_wr1", 1, 1, 32'h00B3);

    // Full depth: limit=0 means all 16 words.
    do_arm(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 16'h0100 + 16'(i), 1'b0);
      if (i == 14) check("full_done_early", 32'(done), 0);
    end
    s_axis.tvalid = 1'b0;
    check("full_done", 32'(done), 1);
    tick();
    check("full_count", 32'(wr_addr_q.size()), 16);
    for (int i = 0; i < 16; i++) check_write("full_wr", i, 32'(i), 32'h0100 + 32'(i));
    check("full_sts", 32'(sts_addr), 15);

    // Idle gaps: tvalid 1,0,1,1,0,1 gives writes C0,C2,C3,C5.
    do_arm(4'd4, 1'b0, 1'b0);
    beat(1'b1, 16'h00C0, 1'b0);
    beat(1'b0, 16'h00C1, 1'b0);
    check("gap_we", 32'(bram_we), 0);
    beat(1'b1, 16'h00C2, 1'b0);
    beat(1'b1, 16'h00C3, 1'b0);
    beat(1'b0, 16'h00C4, 1'b0);
    beat(1'b1, 16'h00C5, 1'b0);
    s_axis.tvalid = 1'b0;
    tick();
    check("gap_done",  32'(done), 1);
    check("gap_count", 32'(wr_addr_q.size()), 4);
    check_write("gap_wr0", 0, 0, 32'h00C0);
    check_write("gap_wr1", 1, 1, 32'h00C2);
    check_write("gap_wr2", 2, 2, 32'h00C3);
    check_write("gap_wr3", 3, 3, 32'h00C5);

    // Reset mid-capture drops the in-flight write; next arm restarts at 0.
    do_arm(4'd4, 1'b0, 1'b0);
    beat(1'b1, 16'h00F0, 1'b0);
    beat(1'b1, 16'h00F1, 1'b0);
    s_axis.tvalid = 1'b0;
    check("rst_pre_we", 32'(bram_we), 32'(2'b11));
    aresetn = 1'b0;
    #1;
    check("rst_async_we",   32'(bram_we), 0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_addr", 32'(bram_addr), 0);
    tick();
    check("rst_count", 32'(wr_addr_q.size()), 1);
    aresetn = 1'b1;
    tick();
    do_arm(4'd2, 1'b0, 1'b0);
    beat(1'b1, 16'h00E0, 1'b0);
    beat(1'b1, 16'h00E1, 1'b0);
    s_axis.tvalid = 1'b0;
    tick();
    check("rst_re_done",  32'(done), 1);
    check("rst_re_count", 32'(wr_addr_q.size()), 2);
    check_write("rst_re_wr0", 0, 0, 32'h00E0);
    check_write("rst_re_wr1", 1, 1, 32'h00E1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
